// File: rtl/prio_enc_rr.sv
// rtl/prio_enc_rr.sv - registered fixed/round-robin priority encoder with valid/ready handshake (optional ENC_MULTIHOT_EN)
module prio_enc_rr #(
    parameter int WIDTH   = 8,
    parameter int IDX_W   = $clog2(WIDTH),
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_req,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_multi,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] off;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   sum;
    logic [WIDTH-1:0] rot;
    logic             accept;
    logic             produce;
    logic             multi;

    // Output register can take a new vector when empty or being drained this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign produce  = accept && enable && (|in_req);

    // Search start: one past the last grant in round-robin mode, bit 0 in fixed mode
    always_comb begin
        start = '0;
        if (RR_MODE != 0) begin
            start = (ptr == IDX_W'(WIDTH - 1)) ? '0 : ptr + IDX_W'(1);
        end
    end

    // Rotate the request so bit 'start' sits at position 0; the doubled copy makes the wrap free
    assign rot = WIDTH'({in_req, in_req} >> start);

    // Lowest set bit of the rotated vector is the offset from the search start
    always_comb begin
        off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    // Map the offset back to an absolute index, modulo WIDTH (works for non-power-of-2 WIDTH)
    always_comb begin
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(WIDTH)) begin
            sel_idx = IDX_W'(sum - (IDX_W + 1)'(WIDTH));
        end else begin
            sel_idx = sum[IDX_W-1:0];
        end
    end

`ifdef ENC_MULTIHOT_EN
    // Clearing the lowest set bit leaves something only when two or more bits were set
    assign multi = |(in_req & (in_req - WIDTH'(1)));
`else
    assign multi = 1'b0;
`endif

    // Output register, round-robin pointer and saturating drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_multi <= 1'b0;
            drop_cnt  <= '0;
            ptr       <= IDX_W'(WIDTH - 1);
        end else begin
            if (produce) begin
                out_valid <= 1'b1;
                out_idx   <= sel_idx;
                out_multi <= multi;
                ptr       <= sel_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !produce && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb/tb_prio_enc_rr.sv - randomized and directed self-checking bench for prio_enc_rr
module tb_prio_enc_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_req;

    always #5 clk = ~clk;

    // Instance 0: WIDTH=8 fixed; instance 1: WIDTH=8 round-robin, CNT_W=2; instance 2: WIDTH=5 round-robin, CNT_W=2
    logic       rdy0, v0, m0, rdy1, v1, m1, rdy2, v2, m2;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] cnt0;
    logic [1:0] cnt1, cnt2;
    logic [4:0] in_req5;

    assign in_req5 = in_req[4:0];

    prio_enc_rr #(.WIDTH(8), .RR_MODE(0), .CNT_W(8)) u_fix (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_req(in_req), .in_valid(in_valid),
        .in_ready(rdy0), .out_idx(idx0), .out_valid(v0), .out_ready(out_ready),
        .out_multi(m0), .drop_cnt(cnt0)
    );

    prio_enc_rr #(.WIDTH(8), .RR_MODE(1), .CNT_W(2)) u_rr (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_req(in_req), .in_valid(in_valid),
        .in_ready(rdy1), .out_idx(idx1), .out_valid(v1), .out_ready(out_ready),
        .out_multi(m1), .drop_cnt(cnt1)
    );

    prio_enc_rr #(.WIDTH(5), .RR_MODE(1), .CNT_W(2)) u_w5 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_req(in_req5), .in_valid(in_valid),
        .in_ready(rdy2), .out_idx(idx2), .out_valid(v2), .out_ready(out_ready),
        .out_multi(m2), .drop_cnt(cnt2)
    );

    int d_idx[3], d_cnt[3];
    bit d_v[3], d_m[3], d_rdy[3];

    always_comb begin
        d_idx[0] = int'(idx0); d_idx[1] = int'(idx1); d_idx[2] = int'(idx2);
        d_cnt[0] = int'(cnt0); d_cnt[1] = int'(cnt1); d_cnt[2] = int'(cnt2);
        d_v[0] = v0;   d_v[1] = v1;   d_v[2] = v2;
        d_m[0] = m0;   d_m[1] = m1;   d_m[2] = m2;
        d_rdy[0] = rdy0; d_rdy[1] = rdy1; d_rdy[2] = rdy2;
    end

    // Reference model state per instance
    const int W[3]    = '{8, 8, 5};
    const int RR[3]   = '{0, 1, 1};
    const int CMAX[3] = '{255, 3, 3};
    int m_idx[3], m_cnt[3], m_ptr[3];
    bit m_v[3], m_m[3];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic bit exp_multi(int req);
`ifdef ENC_MULTIHOT_EN
        return $countones(req) > 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_sel(int u, int req);
        if (RR[u] != 0) begin
            for (int k = 1; k <= W[u]; k++) begin
                if (req[(m_ptr[u] + k) % W[u]]) return (m_ptr[u] + k) % W[u];
            end
        end else begin
            for (int i = 0; i < W[u]; i++) begin
                if (req[i]) return i;
            end
        end
        return 0;
    endfunction

    // Advance the models with the inputs present before the edge, then step the clock
    task automatic tick();
        for (int u = 0; u < 3; u++) begin
            int req;
            bit rdy;
            req = int'(in_req) & ((1 << W[u]) - 1);
            rdy = !m_v[u] || out_ready;
            if (!rst_n) begin
                m_v[u] = 0; m_idx[u] = 0; m_m[u] = 0; m_cnt[u] = 0; m_ptr[u] = W[u] - 1;
            end else if (in_valid && rdy) begin
                if (enable && req != 0) begin
                    m_idx[u] = model_sel(u, req);
                    m_ptr[u] = m_idx[u];
                    m_m[u]   = exp_multi(req);
                    m_v[u]   = 1;
                end else begin
                    m_v[u] = 0;
                    if (m_cnt[u] < CMAX[u]) m_cnt[u]++;
                end
            end else if (out_ready) begin
                m_v[u] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; enable = 1; out_ready = 1; in_req = 8'h00;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 1; enable = 1; out_ready = 0; in_req = 8'hFF;
        tick();
        for (int u = 0; u < 3; u++) begin
            n_chk++; if (d_v[u] !== 1'b0) begin n_fail++; $display("FAIL reset_valid u%0d: got %0d expected 0", u, d_v[u]); end
            n_chk++; if (d_idx[u] !== 0) begin n_fail++; $display("FAIL reset_idx u%0d: got %0d expected 0", u, d_idx[u]); end
            n_chk++; if (d_cnt[u] !== 0) begin n_fail++; $display("FAIL reset_cnt u%0d: got %0d expected 0", u, d_cnt[u]); end
            n_chk++; if (d_m[u] !== 1'b0) begin n_fail++; $display("FAIL reset_multi u%0d: got %0d expected 0", u, d_m[u]); end
            n_chk++; if (d_rdy[u] !== 1'b1) begin n_fail++; $display("FAIL reset_ready u%0d: got %0d expected 1", u, d_rdy[u]); end
        end
        rst_n = 1; in_valid = 0;
        #1;
        n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %0d expected 1", rdy0); end
    endtask

    task automatic test_fixed();
        do_reset();
        in_valid = 1; enable = 1; out_ready = 1; in_req = 8'b0010_1000;
        tick();
        n_chk++; if (idx0 !== 3'd3 || v0 !== 1'b1) begin n_fail++; $display("FAIL fixed_0x28: got idx %0d valid %0d expected idx 3 valid 1", idx0, v0); end
        n_chk++; if (m0 !== exp_multi(8'h28)) begin n_fail++; $display("FAIL fixed_multi_0x28: got %0d expected %0d", m0, exp_multi(8'h28)); end
        in_req = 8'b1000_0000;
        tick();
        n_chk++; if (idx0 !== 3'd7 || m0 !== 1'b0) begin n_fail++; $display("FAIL fixed_0x80: got idx %0d multi %0d expected idx 7 multi 0", idx0, m0); end
    endtask

    task automatic test_rr();
        int exp_seq[4] = '{0, 7, 0, 4};
        do_reset();
        in_valid = 1; enable = 1; out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            in_req = (k < 3) ? 8'b1000_0001 : 8'b0001_0000;
            tick();
            n_chk++; if (idx1 !== 3'(exp_seq[k]) || v1 !== 1'b1) begin n_fail++; $display("FAIL rr_seq step %0d: got idx %0d valid %0d expected idx %0d valid 1", k, idx1, v1, exp_seq[k]); end
        end
    endtask

    task automatic test_drops();
        do_reset();
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            enable = (k >= 3); in_req = (k < 3) ? 8'hFF : 8'h00;
            tick();
            n_chk++; if (v0 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL drop_valid step %0d: got %0d/%0d expected 0/0", k, v0, v1); end
        end
        n_chk++; if (cnt0 !== 8'd5) begin n_fail++; $display("FAIL drop_cnt: got %0d expected 5", cnt0); end
        n_chk++; if (cnt1 !== 2'd3 || cnt2 !== 2'd3) begin n_fail++; $display("FAIL drop_cnt_sat: got %0d/%0d expected 3/3", cnt1, cnt2); end
        enable = 1; in_req = 8'h01;
        tick();
        n_chk++; if (idx1 !== 3'd0 || v1 !== 1'b1) begin n_fail++; $display("FAIL drop_ptr_kept: got idx %0d valid %0d expected idx 0 valid 1", idx1, v1); end
        in_req = 8'h04; tick();
        enable = 0; in_req = 8'hFF; tick();
        enable = 1; in_req = 8'h24; tick();
        n_chk++; if (idx1 !== 3'd5) begin n_fail++; $display("FAIL drop_ptr_after_grant: got %0d expected 5", idx1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1; enable = 1; out_ready = 1; in_req = 8'h04;
        tick();
        n_chk++; if (idx0 !== 3'd2 || v0 !== 1'b1) begin n_fail++; $display("FAIL bp_first: got idx %0d valid %0d expected idx 2 valid 1", idx0, v0); end
        out_ready = 0; in_req = 8'h10;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (rdy0 !== 1'b0 || idx0 !== 3'd2 || v0 !== 1'b1) begin n_fail++; $display("FAIL bp_hold cycle %0d: got ready %0d idx %0d valid %0d expected 0 2 1", k, rdy0, idx0, v0); end
        end
        out_ready = 1;
        #1;
        n_chk++; if (rdy0 !== 1'b1 || idx0 !== 3'd2) begin n_fail++; $display("FAIL bp_release: got ready %0d idx %0d expected 1 2", rdy0, idx0); end
        tick();
        n_chk++; if (idx0 !== 3'd4 || v0 !== 1'b1) begin n_fail++; $display("FAIL bp_next: got idx %0d valid %0d expected idx 4 valid 1", idx0, v0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1; enable = 1; out_ready = 1; in_req = 8'h20;
        tick();
        out_ready = 0;
        tick();
        n_chk++; if (idx1 !== 3'd5 || v1 !== 1'b1) begin n_fail++; $display("FAIL rmid_hold: got idx %0d valid %0d expected 5 1", idx1, v1); end
        rst_n = 0;
        tick();
        n_chk++; if (v1 !== 1'b0 || cnt1 !== 2'd0) begin n_fail++; $display("FAIL rmid_reset: got valid %0d cnt %0d expected 0 0", v1, cnt1); end
        rst_n = 1; out_ready = 1; in_req = 8'b0010_0001;
        tick();
        n_chk++; if (idx1 !== 3'd0 || v1 !== 1'b1) begin n_fail++; $display("FAIL rmid_next: got idx %0d valid %0d expected 0 1", idx1, v1); end
    endtask

    task automatic test_nonpow2();
        do_reset();
        in_valid = 1; enable = 1; out_ready = 1; in_req = 8'b0001_0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (idx2 !== ((k % 2 == 0) ? 3'd0 : 3'd4)) begin n_fail++; $display("FAIL w5_alt step %0d: got %0d expected %0d", k, idx2, (k % 2 == 0) ? 0 : 4); end
            n_chk++; if (u_w5.ptr > 3'd4) begin n_fail++; $display("FAIL w5_ptr_range: got %0d expected <= 4", u_w5.ptr); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 99) >= 2);
            in_valid  = ($urandom_range(0, 99) < 80);
            enable    = ($urandom_range(0, 99) < 85);
            out_ready = ($urandom_range(0, 99) < 70);
            in_req    = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            #1;
            for (int u = 0; u < 3; u++) begin
                n_chk++; if (d_rdy[u] !== (!m_v[u] || out_ready)) begin n_fail++; $display("FAIL rnd_ready c%0d u%0d: got %0d expected %0d", c, u, d_rdy[u], !m_v[u] || out_ready); end
            end
            tick();
            for (int u = 0; u < 3; u++) begin
                n_chk++; if (d_v[u] !== m_v[u]) begin n_fail++; $display("FAIL rnd_valid c%0d u%0d: got %0d expected %0d", c, u, d_v[u], m_v[u]); end
                n_chk++; if (d_cnt[u] !== m_cnt[u]) begin n_fail++; $display("FAIL rnd_cnt c%0d u%0d: got %0d expected %0d", c, u, d_cnt[u], m_cnt[u]); end
                if (m_v[u]) begin
                    n_chk++; if (d_idx[u] !== m_idx[u]) begin n_fail++; $display("FAIL rnd_idx c%0d u%0d: got %0d expected %0d", c, u, d_idx[u], m_idx[u]); end
                    n_chk++; if (d_m[u] !== m_m[u]) begin n_fail++; $display("FAIL rnd_multi c%0d u%0d: got %0d expected %0d", c, u, d_m[u], m_m[u]); end
                end
            end
            n_chk++; if (u_w5.ptr > 3'd4) begin n_fail++; $display("FAIL rnd_w5_ptr c%0d: got %0d expected <= 4", c, u_w5.ptr); end
        end
    endtask

    initial begin
        rst_n = 0; enable = 0; in_valid = 0; out_ready = 1; in_req = 8'h00;
        #2;
        test_reset();
        test_fixed();
        test_rr();
        test_drops();
        test_backpressure();
        test_reset_mid();
        test_nonpow2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_enc_rr.md
# prio_enc_rr

Parametrised, registered priority encoder that reduces a WIDTH-bit request vector to a binary index. It extends the 8-to-3 one-hot encoder with the following:
- arbitrary width;
- selectable fixed-LSB or round-robin priority;
- a valid/ready handshake on both sides;
- a saturating count of dropped empty or disabled vectors.

It sits between request sources (interrupt lines, channel requests) and any consumer of a single granted index.

## Interface
Parameters:
- WIDTH, 8, request vector width; legal range 2..256.
- IDX_W, $clog2(WIDTH), index width; derived, never overridden.
- RR_MODE, 0, priority mode: 0 = fixed (bit 0 highest), 1 = round-robin.
- CNT_W, 8, width of drop_cnt.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  encode enable; sampled with each accepted vector.
- in_req  input  WIDTH  request vector.
- in_valid  input  1  in_req valid.
- in_ready  output  1  block can accept in_req this cycle.
- out_idx  output  IDX_W  encoded index.
- out_valid  output  1  out_idx valid.
- out_ready  input  1  consumer takes out_idx this cycle.
- out_multi  output  1  more than one request bit was set in the encoded vector (see Configuration).
- drop_cnt  output  CNT_W  saturating count of accepted vectors that produced no output.

## Operation
Output register:
- Single-entry output register (out_idx, out_multi, out_valid).
- in_ready = !out_valid || out_ready. This is combinational, with no path from in_valid.

Accept and produce:
- A vector is accepted when in_valid && in_ready.
- An accepted vector produces an output only when enable=1 and in_req != 0. It is then loaded into the output register and out_valid is set.

Drop:
- An accepted vector with enable=0 or in_req=0 is dropped.
- No output is produced and drop_cnt increments, saturating at 2^CNT_W-1.
- If the output register is being consumed in that cycle, out_valid clears.

Selection:
- RR_MODE=0: out_idx = index of the lowest set bit of in_req.
- RR_MODE=1: the search starts at (ptr+1) mod WIDTH and proceeds upward with wrap-around. out_idx is the first set bit found.
  - ptr is an internal IDX_W register. It is loaded with out_idx only on an accepted, producing vector.
  - ptr is unchanged on drops and on stalls.
- Wrap arithmetic is modulo WIDTH, including non-power-of-2 WIDTH. ptr never holds a value >= WIDTH.

Consume and hold:
- When out_valid && out_ready and no new vector is produced, out_valid clears.
- Simultaneous consume and accept: the new value replaces the old one and out_valid stays 1.
- While out_valid && !out_ready, out_idx and out_multi hold stable. in_ready=0, so in_req is ignored.

## Timing
- Latency: 1 cycle. A vector accepted at edge N appears on out_idx/out_valid after edge N.
- Throughput: 1 vector/cycle when out_ready=1 continuously.
- drop_cnt updates at the same edge as the accepting drop.
- Reset (rst_n=0 at an edge) sets:
  - out_valid=0, out_idx=0, out_multi=0, drop_cnt=0;
  - ptr=WIDTH-1, so the first round-robin search starts at bit 0.
- Reset mid-operation discards any held output without handshake.
- in_ready=1 during and immediately after reset.
- All outputs are registered except in_ready.

## Configuration
- ENC_MULTIHOT_EN defined: out_multi is registered with out_idx. It is 1 when popcount(in_req) > 1 for the produced vector, and 0 otherwise.
- ENC_MULTIHOT_EN undefined: no popcount logic is built and out_multi is tied to 0. Port list is identical in both builds.

## Test plan
Unless stated, WIDTH=8 and out_ready=1.
- Fixed priority (RR_MODE=0), enable=1: in_req=8'b0010_1000 -> out_idx=3, out_valid=1 one cycle later, out_multi=1 with ENC_MULTIHOT_EN (0 without). in_req=8'b1000_0000 -> out_idx=7, out_multi=0.
- Round-robin (RR_MODE=1) after reset, in_req=8'b1000_0001 applied 3 consecutive cycles -> out_idx sequence 0, 7, 0. Then in_req=8'b0001_0000 -> out_idx=4.
- Drops: enable=0 with in_req=8'hFF for 3 cycles, then enable=1 with in_req=0 for 2 cycles -> no out_valid, drop_cnt=5, ptr unchanged (next 8'h01 yields out_idx=0). With CNT_W=2, 5 drops -> drop_cnt=3 (saturated).
- Backpressure: produce out_idx=2, then hold out_ready=0 for 4 cycles while in_req=8'h10 with in_valid=1:
  - in_ready=0 and out_idx stays 2;
  - when out_ready rises, 2 is consumed and out_idx=4 is valid the next cycle.
- Reset mid-stream (RR_MODE=1): out_idx=5 held with out_ready=0, then rst_n=0 for one edge -> out_valid=0, drop_cnt=0. Next in_req=8'b0010_0001 -> out_idx=0.
- Non-power-of-2 (WIDTH=5, RR_MODE=1): in_req=5'b10001 repeated -> out_idx alternates 0, 4, 0, 4. ptr never exceeds 4.
